// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit on-the-fly converter.
// Optional feature macro: SD_CONV_ZERO_EN (adds the out_zero result flag).
package sd_pkg;

  // Borrow-save digit codes, {plus, minus}; 2'b11 also decodes to zero.
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Returns {is_pos, is_neg}; both low for either zero code.
  function automatic logic [1:0] sd_decode(input logic [1:0] code);
    sd_decode = {code == SD_POS, code == SD_NEG};
  endfunction

endpackage

// File: rtl/sd_otf_converter_if.sv
// Digit-in / result-out handshake bundle for sd_otf_converter.
// Optional feature macro: SD_CONV_ZERO_EN (adds out_zero).
interface sd_otf_converter_if #(
  parameter int unsigned DIGITS = 16
);

  logic            in_valid;
  logic            in_ready;
  logic            d_plus;
  logic            d_minus;
  logic            out_valid;
  logic            out_ready;
  logic [DIGITS:0] out_q;
`ifdef SD_CONV_ZERO_EN
  logic            out_zero;
`endif

  modport master (
    output in_valid, d_plus, d_minus, out_ready,
`ifdef SD_CONV_ZERO_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_q
  );

  modport slave (
    input  in_valid, d_plus, d_minus, out_ready,
`ifdef SD_CONV_ZERO_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_q
  );

endinterface

// File: rtl/sd_otf_converter_digit_update.sv
// One on-the-fly conversion step: appends a digit to the Q/QM pair.
module otfc_digit_update #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_qm,
  input  logic         i_pos,
  input  logic         i_neg,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_qm
);

  // Select source register and appended bit; the MSB shifted out is a sign copy.
  always_comb begin
    o_q  = {i_q[W-2:0], 1'b0};
    o_qm = {i_qm[W-2:0], 1'b1};
    if (i_pos) begin
      o_q  = {i_q[W-2:0], 1'b1};
      o_qm = {i_q[W-2:0], 1'b0};
    end else if (i_neg) begin
      o_q  = {i_qm[W-2:0], 1'b1};
      o_qm = {i_qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_otf_converter.sv
// Serial on-the-fly converter: MSD-first borrow-save digits to a
// two's-complement fraction of DIGITS bits plus sign.
// Optional feature macro: SD_CONV_ZERO_EN (registered out_zero flag).
module sd_otf_converter
  import sd_pkg::*;
#(
  parameter int unsigned DIGITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  sd_otf_converter_if.slave   bus
);

  localparam int unsigned W     = DIGITS + 1;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_qm;
  logic [W-1:0]     w_q_upd;
  logic [W-1:0]     w_qm_upd;
  logic [W-1:0]     w_q_nxt;
  logic [W-1:0]     w_qm_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_dec;
  logic             r_in_ready;
  logic             r_out_valid;

  assign w_dec = sd_decode({bus.d_plus, bus.d_minus});

  otfc_digit_update #(.W(W)) u_digit_update (
    .i_q   (r_q),
    .i_qm  (r_qm),
    .i_pos (w_dec[1]),
    .i_neg (w_dec[0]),
    .o_q   (w_q_upd),
    .o_qm  (w_qm_upd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_state_nxt;
  end

  // Next state and next datapath values.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_qm_nxt    = r_qm;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ACC: begin
        if (bus.in_valid) begin
          w_q_nxt   = w_q_upd;
          w_qm_nxt  = w_qm_upd;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIGITS - 1)) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ACC;
          w_q_nxt     = '0;
          w_qm_nxt    = '1;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  // Q/QM pair, digit counter and handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      r_qm        <= '1;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_q         <= w_q_nxt;
      r_qm        <= w_qm_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ACC);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_q     = r_q;

`ifdef SD_CONV_ZERO_EN
  logic r_zero;

  // Zero flag captured on DONE entry, dropped when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (r_state == ACC && w_state_nxt == DONE) begin
      r_zero <= (w_q_nxt == '0);
    end else if (w_state_nxt == ACC) begin
      r_zero <= 1'b0;
    end
  end

  assign bus.out_zero = r_zero;
`endif

endmodule

// File: tb/tb_sd_otf_converter.sv
// Scoreboard bench for sd_otf_converter with DIGITS=4.
module tb_sd_otf_converter;

  localparam int unsigned DIGITS = 4;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] B = 2'b11;

  logic clk;
  logic rst;

  sd_otf_converter_if #(.DIGITS(DIGITS)) bus ();

  sd_otf_converter #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DIGITS:0] q;
    logic            zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one digit (called at a negedge); returns at the negedge after its handshake.
  task automatic send_digit(input logic [1:0] code);
    int n = 0;
    bus.d_plus   = code[1];
    bus.d_minus  = code[0];
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Send four digits (packed MSD first) with optional idle gaps, queue the expected result.
  task automatic send_word(input logic [7:0] digs, input int gap,
                           input logic [DIGITS:0] q, input logic zero);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pre_valid", 32'(bus.out_valid), 32'd0);
      send_digit(digs[7-2*i -: 2]);
      if (i < 3 && gap > 0) begin
        bus.in_valid = 1'b0;
        bus.d_plus   = 1'b1;
        bus.d_minus  = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    e.q    = q;
    e.zero = zero;
    exp_q.push_back(e);
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
  endtask

  // Monitor: compare each consumed result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_q), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_q", 32'(bus.out_q), 32'(e.q));
`ifdef SD_CONV_ZERO_EN
          chk("out_zero", 32'(bus.out_zero), 32'(e.zero));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.d_plus    = 1'b0;
    bus.d_minus   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_q", 32'(bus.out_q), 32'd0);
`ifdef SD_CONV_ZERO_EN
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    send_word({P, N, Z, P}, 0, 5'b00101, 1'b0);
    send_word({N, N, N, N}, 0, 5'b10001, 1'b0);
    send_word({P, P, P, P}, 0, 5'b01111, 1'b0);
    send_word({B, Z, B, Z}, 0, 5'b00000, 1'b1);
    send_word({P, N, N, N}, 0, 5'b00001, 1'b0);
    send_word({P, Z, Z, N}, 2, 5'b00111, 1'b0);

    // Back-pressure: result must hold while digits are offered.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_word({P, P, P, P}, 0, 5'b01111, 1'b0);
    bus.in_valid = 1'b1;
    bus.d_plus   = 1'b0;
    bus.d_minus  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_q", 32'(bus.out_q), 32'(5'b01111));
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-accumulation, with a digit handshake in the same cycle.
    send_digit(P);
    send_digit(P);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_q", 32'(bus.out_q), 32'd0);
    send_word({P, P, Z, Z}, 0, 5'b01100, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_otf_converter.md
# sd_otf_converter

Serial on-the-fly converter that turns the MSD-first borrow-save digit stream from the online adder/multiplier datapath into a conventional two's-complement word. It consumes one redundant radix-2 digit (plus/minus bit pair) per handshake, maintains the Ercegovac Q/QM register pair so no carry propagation is ever needed, and presents the finished fraction after `DIGITS` digits. It sits directly downstream of the signed-digit adder chain, at the boundary between the online datapath and non-redundant consumers.

## Interface
- `DIGITS`, 16: fractional digits per result, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  digit present.
- `in_ready`  out  1  converter accepts a digit this cycle.
- `d_plus`  in  1  positive rail of digit.
- `d_minus`  in  1  negative rail of digit.
- `out_valid`  out  1  `out_q` holds a finished result.
- `out_ready`  in  1  consumer takes result.
- `out_q`  out  DIGITS+1  two's-complement result: 1 sign bit, DIGITS fraction bits (value = out_q·2^-DIGITS).
- `out_zero`  out  1  result equals zero (only with `SD_CONV_ZERO_EN`).

## Operation
- Digit decode: (1,0)=+1, (0,1)=−1, (0,0) and (1,1)=0; all four codes legal.
- Registers Q, QM, width DIGITS+1, integer view of partial value; invariant QM = Q−1.
- Update per accepted digit d: d=+1: Q←{Q,1}, QM←{Q,0}; d=0: Q←{Q,0}, QM←{QM,1}; d=−1: Q←{QM,1}, QM←{QM,0} (left shift by one, MSB dropped).
- Initial Q = all zeros, QM = all ones (−1); dropped MSBs are sign copies, so no overflow for any digit sequence.
- Digit counter `cnt`, width $clog2(DIGITS+1), 0..DIGITS.
- FSM states:
  - ACC: `in_ready`=1, `out_valid`=0. Accepted digit updates Q/QM, `cnt`++. Accept with `cnt`=DIGITS−1 → DONE.
  - DONE: `in_ready`=0, `out_valid`=1, `out_q`=Q held stable. `out_ready`=1 → ACC with Q=0, QM=all ones, `cnt`=0.
- `in_valid`=0 in ACC: registers hold, no timeout.
- Digit inputs ignored in DONE; no bypass of finished result to new digits.

## Timing
- Reset values: state ACC, Q=0, QM=all ones, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_q`=0, `out_zero`=0.
- `in_ready` and `out_valid` driven from state register only (no combinational path from `in_valid`/`out_ready`).
- Latency: `out_valid` rises the cycle after the DIGITS-th digit handshake.
- Throughput: DIGITS+1 cycles per result minimum; each extra `out_ready`-low cycle in DONE adds one.
- `rst` mid-accumulation or in DONE: next cycle equals reset state; partial result discarded, no output.
- `rst` and handshake same cycle: reset wins.

## Configuration
- `SD_CONV_ZERO_EN` defined: `out_zero` port present; registered flag set with DONE entry when final Q is all zeros, held through DONE, cleared on leaving DONE and on reset.
- Undefined: `out_zero` port and its logic absent; all other behaviour identical.

## Structure
- Shared package `sd_pkg`: digit code localparams (SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00), FSM state typedef (`ACC`, `DONE`), digit decode function returning {is_pos, is_neg}.
- One sub-module `otfc_digit_update`: combinational, takes Q, QM, digit; returns next Q, QM. Top holds FSM, counter, registers.

## Test plan
- DIGITS=4, digits +1,−1,0,+1 back-to-back → `out_valid` on cycle 5, `out_q`=5'b00101 (5/16).
- DIGITS=4, four −1 digits → `out_q`=5'b10001 (−15/16); four +1 → 5'b01111.
- DIGITS=4, digits (1,1),(0,0),(1,1),(0,0) → `out_q`=0, `out_zero`=1 with macro; digits +1,−1,−1,−1 → `out_q`=5'b00001, `out_zero`=0.
- `in_valid` gaps of 2 cycles between digits +1,0,0,−1 → `out_q`=5'b00111; Q/QM unchanged across gaps.
- Result held with `out_ready`=0 for 3 cycles → `out_q` stable, `in_ready`=0, digits presented meanwhile ignored; `out_ready`=1 → ACC next cycle.
- `rst` pulsed after 2 of 4 digits → reset state next cycle; following 4 digits +1,+1,0,0 → `out_q`=5'b01100.
